// File: rtl/calc_pkg.sv
// Shared types for the calculator request port: command/response encodings and port FSM states.
package calc_pkg;
  localparam int CALC_W = 32;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2,
    RESP_INV  = 2'd3
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND1,
    ST_SEND2,
    ST_WAIT,
    ST_DONE
  } port_state_e;

  typedef struct packed {
    logic [3:0]        cmd;
    logic [CALC_W-1:0] op1;
    logic [CALC_W-1:0] op2;
  } calc_op_t;
endpackage

// File: rtl/calc_expect.sv
// Combinational reference of the calculator result, used for response checking.
// Only present when CALC_PORT_CHECK_EN is defined.
`ifdef CALC_PORT_CHECK_EN
module calc_expect
  import calc_pkg::*;
(
  input  logic [3:0]        i_cmd,
  input  logic [CALC_W-1:0] i_op1,
  input  logic [CALC_W-1:0] i_op2,
  output resp_e             o_resp,
  output logic [CALC_W-1:0] o_data
);
  logic [CALC_W:0] w_sum;
  assign w_sum = {1'b0, i_op1} + {1'b0, i_op2};

  always_comb begin
    o_resp = RESP_NONE;
    o_data = '0;
    case (i_cmd)
      CMD_NOP: o_resp = RESP_NONE;
      CMD_ADD: begin
        if (w_sum[CALC_W]) o_resp = RESP_ERR;
        else begin
          o_resp = RESP_OK;
          o_data = w_sum[CALC_W-1:0];
        end
      end
      CMD_SUB: begin
        if (i_op1 < i_op2) o_resp = RESP_ERR;
        else begin
          o_resp = RESP_OK;
          o_data = i_op1 - i_op2;
        end
      end
      CMD_SHL: begin
        o_resp = RESP_OK;
        o_data = i_op1 << i_op2[4:0];
      end
      CMD_SHR: begin
        o_resp = RESP_OK;
        o_data = i_op1 >> i_op2[4:0];
      end
      default: o_resp = RESP_INV;
    endcase
  end
endmodule
`endif

// File: rtl/calc_req_port.sv
// Per-channel request issuer: accepts {cmd,op1,op2}, drives the two-cycle request, waits for the
// channel response or a timeout, and returns the result. CALC_PORT_CHECK_EN adds result checking.
module calc_req_port
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 10,
  parameter int CNT_W   = 4
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_cmd,
  input  logic [CALC_W-1:0] op_data1,
  input  logic [CALC_W-1:0] op_data2,
  output logic [3:0]        req_cmd_out,
  output logic [CALC_W-1:0] req_data_out,
  input  logic [1:0]        calc_resp_in,
  input  logic [CALC_W-1:0] calc_data_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_resp,
  output logic [CALC_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic [CNT_W-1:0]  rsp_cycles,
  output logic              rsp_mismatch
);
  port_state_e       r_state, w_nx_state;
  calc_op_t          r_op, w_nx_op;
  logic [CNT_W-1:0]  r_cnt, w_nx_cnt;
  logic              r_op_ready, w_nx_op_ready;
  logic [3:0]        r_req_cmd, w_nx_req_cmd;
  logic [CALC_W-1:0] r_req_data, w_nx_req_data;
  logic              r_rsp_valid, w_nx_rsp_valid;
  logic [1:0]        r_rsp_resp, w_nx_rsp_resp;
  logic [CALC_W-1:0] r_rsp_data, w_nx_rsp_data;
  logic              r_rsp_timeout, w_nx_rsp_timeout;
  logic [CNT_W-1:0]  r_rsp_cycles, w_nx_rsp_cycles;
  logic              r_rsp_mismatch, w_nx_rsp_mismatch;

  // What would be captured this cycle: a nonzero response with its data, or zeros on timeout.
  logic [1:0]        w_cap_resp;
  logic [CALC_W-1:0] w_cap_data;
  logic              w_mismatch;
  assign w_cap_resp = calc_resp_in;
  assign w_cap_data = (calc_resp_in != 2'd0) ? calc_data_in : '0;

`ifdef CALC_PORT_CHECK_EN
  resp_e             w_exp_resp;
  logic [CALC_W-1:0] w_exp_data;

  calc_expect u_expect (
    .i_cmd  (r_op.cmd),
    .i_op1  (r_op.op1),
    .i_op2  (r_op.op2),
    .o_resp (w_exp_resp),
    .o_data (w_exp_data)
  );

  // Data only matters when the model says OK; a timeout matches only a NOP (expected resp 0).
  assign w_mismatch = (w_cap_resp != w_exp_resp) ||
                      ((w_exp_resp == RESP_OK) && (w_cap_data != w_exp_data));
`else
  logic w_unused;
  assign w_unused   = ^{r_op.cmd, r_op.op1};
  assign w_mismatch = 1'b0;
`endif

  always_comb begin
    w_nx_state        = r_state;
    w_nx_op           = r_op;
    w_nx_cnt          = r_cnt;
    w_nx_op_ready     = r_op_ready;
    w_nx_req_cmd      = '0;
    w_nx_req_data     = '0;
    w_nx_rsp_valid    = r_rsp_valid;
    w_nx_rsp_resp     = r_rsp_resp;
    w_nx_rsp_data     = r_rsp_data;
    w_nx_rsp_timeout  = r_rsp_timeout;
    w_nx_rsp_cycles   = r_rsp_cycles;
    w_nx_rsp_mismatch = r_rsp_mismatch;
    case (r_state)
      ST_IDLE: begin
        if (op_valid && r_op_ready) begin
          w_nx_state    = ST_SEND1;
          w_nx_op       = '{cmd: op_cmd, op1: op_data1, op2: op_data2};
          w_nx_op_ready = 1'b0;
          w_nx_req_cmd  = op_cmd;
          w_nx_req_data = op_data1;
        end
      end
      ST_SEND1: begin
        w_nx_state    = ST_SEND2;
        w_nx_req_data = r_op.op2;
      end
      ST_SEND2: begin
        w_nx_state = ST_WAIT;
        w_nx_cnt   = '0;
      end
      ST_WAIT: begin
        w_nx_cnt = r_cnt + CNT_W'(1);
        // A response arriving on the last wait cycle still counts as a capture.
        if (calc_resp_in != 2'd0 || r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_nx_state        = ST_DONE;
          w_nx_rsp_valid    = 1'b1;
          w_nx_rsp_resp     = w_cap_resp;
          w_nx_rsp_data     = w_cap_data;
          w_nx_rsp_timeout  = (calc_resp_in == 2'd0);
          w_nx_rsp_cycles   = r_cnt;
          w_nx_rsp_mismatch = w_mismatch;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          w_nx_state     = ST_IDLE;
          w_nx_rsp_valid = 1'b0;
          w_nx_op_ready  = 1'b1;
        end
      end
      default: w_nx_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_op           <= '0;
      r_cnt          <= '0;
      r_op_ready     <= 1'b1;
      r_req_cmd      <= '0;
      r_req_data     <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_resp     <= '0;
      r_rsp_data     <= '0;
      r_rsp_timeout  <= 1'b0;
      r_rsp_cycles   <= '0;
      r_rsp_mismatch <= 1'b0;
    end else begin
      r_state        <= w_nx_state;
      r_op           <= w_nx_op;
      r_cnt          <= w_nx_cnt;
      r_op_ready     <= w_nx_op_ready;
      r_req_cmd      <= w_nx_req_cmd;
      r_req_data     <= w_nx_req_data;
      r_rsp_valid    <= w_nx_rsp_valid;
      r_rsp_resp     <= w_nx_rsp_resp;
      r_rsp_data     <= w_nx_rsp_data;
      r_rsp_timeout  <= w_nx_rsp_timeout;
      r_rsp_cycles   <= w_nx_rsp_cycles;
      r_rsp_mismatch <= w_nx_rsp_mismatch;
    end
  end

  assign op_ready     = r_op_ready;
  assign req_cmd_out  = r_req_cmd;
  assign req_data_out = r_req_data;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_resp     = r_rsp_resp;
  assign rsp_data     = r_rsp_data;
  assign rsp_timeout  = r_rsp_timeout;
  assign rsp_cycles   = r_rsp_cycles;
  assign rsp_mismatch = r_rsp_mismatch;
endmodule

// File: tb/tb_calc_req_port.sv
// Randomized scoreboard bench for calc_req_port: a driver plays both the op source and the
// calculator channel, a monitor checks every returned result against a behavioural model.
module tb_calc_req_port;
  localparam int TIMEOUT = 10;
  localparam int CNT_W   = 4;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_data1, op_data2;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  calc_resp_in;
  logic [31:0] calc_data_in;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic [CNT_W-1:0] rsp_cycles;
  logic        rsp_mismatch;

  always #5 c_clk = ~c_clk;

  calc_req_port #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .c_clk(c_clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
    .op_data1(op_data1), .op_data2(op_data2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .calc_resp_in(calc_resp_in), .calc_data_in(calc_data_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles), .rsp_mismatch(rsp_mismatch)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic        to;
    logic [3:0]  cyc;
    logic        mm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Calculator semantics straight from the command definitions.
  function automatic void model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                output logic [1:0] r, output logic [31:0] d);
    logic [63:0] s;
    r = 2'd0;
    d = 32'd0;
    s = {32'd0, a} + {32'd0, b};
    case (cmd)
      4'd0: r = 2'd0;
      4'd1: if (s > 64'hFFFF_FFFF) r = 2'd2; else begin r = 2'd1; d = s[31:0]; end
      4'd2: if (a < b) r = 2'd2; else begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << (b % 32); end
      4'd6: begin r = 2'd1; d = a >> (b % 32); end
      default: r = 2'd3;
    endcase
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_op_ready"}, op_ready, 1);
    chk({tag, "_req_cmd"}, req_cmd_out, 0);
    chk({tag, "_req_data"}, req_data_out, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_resp"}, rsp_resp, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_rsp_cycles"}, rsp_cycles, 0);
    chk({tag, "_rsp_mismatch"}, rsp_mismatch, 0);
  endtask

  // Issue one op and act as the channel: respond dresp/ddata in wait cycle d (dresp 0 = never).
  task automatic do_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] dresp, input logic [31:0] ddata, input int d, input bit stale);
    exp_t e;
    logic [1:0] mr;
    logic [31:0] md;
    int n;
    int exp_lat;
    bit got;
    model(cmd, a, b, mr, md);
    if (dresp != 2'd0 && d <= TIMEOUT - 1) begin
      e = '{dresp, ddata, 1'b0, 4'(d), 1'b0};
      exp_lat = d + 1;
    end else begin
      e = '{2'd0, 32'd0, 1'b1, 4'(TIMEOUT - 1), 1'b0};
      exp_lat = TIMEOUT;
    end
`ifdef CALC_PORT_CHECK_EN
    e.mm = (e.resp != mr) || (mr == 2'd1 && e.data != md);
`endif
    op_valid = 1'b1; op_cmd = cmd; op_data1 = a; op_data2 = b;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge c_clk);
      if (op_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk("op_ready_wait", 0, 1);
      op_valid = 1'b0;
      return;
    end
    @(posedge c_clk);
    q.push_back(e);
    #1;
    op_valid = 1'b0;
    op_cmd = $urandom; op_data1 = $urandom; op_data2 = $urandom;
    calc_resp_in = stale ? 2'd3 : 2'd0;
    calc_data_in = $urandom;
    @(negedge c_clk);
    chk("send1_cmd", req_cmd_out, cmd);
    chk("send1_data", req_data_out, a);
    chk("send1_op_ready", op_ready, 0);
    @(posedge c_clk); #1;
    @(negedge c_clk);
    chk("send2_cmd", req_cmd_out, 0);
    chk("send2_data", req_data_out, b);
    @(posedge c_clk); #1;
    n = 0;
    calc_resp_in = (n == d) ? dresp : 2'd0;
    calc_data_in = (n == d && dresp != 2'd0) ? ddata : $urandom;
    got = 1'b0;
    for (int it = 0; it < 50; it++) begin
      @(negedge c_clk);
      if (rsp_valid) begin got = 1'b1; break; end
      if (n == 0) chk("wait_req", {req_cmd_out, req_data_out}, 0);
      @(posedge c_clk); #1;
      n++;
      calc_resp_in = (n == d) ? dresp : 2'd0;
      calc_data_in = (n == d && dresp != 2'd0) ? ddata : $urandom;
    end
    if (got) chk("rsp_latency", n, exp_lat);
    else     chk("rsp_valid_wait", 0, 1);
    calc_resp_in = 2'd0;
  endtask

  // Monitor: pops an expectation on each new result, then holds it stable until the handshake.
  initial begin
    exp_t e;
    logic [39:0] snap;
    bit have;
    have = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge c_clk);
      if (reset) have = 1'b0;
      else if (rsp_valid) begin
        if (!have) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no pending op");
          end else begin
            e = q.pop_front();
            chk("rsp_resp", rsp_resp, e.resp);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_timeout", rsp_timeout, e.to);
            chk("rsp_cycles", rsp_cycles, e.cyc);
            chk("rsp_mismatch", rsp_mismatch, e.mm);
          end
          snap = {rsp_resp, rsp_data, rsp_timeout, rsp_cycles, rsp_mismatch};
          have = 1'b1;
        end else
          chk("rsp_stable", {rsp_resp, rsp_data, rsp_timeout, rsp_cycles, rsp_mismatch}, snap);
        chk("op_ready_in_done", op_ready, 0);
        if (rsp_ready) have = 1'b0;
      end
      @(posedge c_clk); #1;
      rsp_ready = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cmd;
    logic [31:0] a, b, md;
    logic [1:0] mr, dr;
    logic [31:0] dd;
    bit any_valid;
    reset = 1'b1; op_valid = 1'b0; op_cmd = '0; op_data1 = '0; op_data2 = '0;
    calc_resp_in = '0; calc_data_in = '0;
    repeat (2) @(posedge c_clk);
    @(negedge c_clk);
    chk_reset_outputs("reset");
    @(posedge c_clk); #1;
    reset = 1'b0;

    do_op(4'd1, 32'h5, 32'h1, 2'd1, 32'h6, 2, 1'b0);
    do_op(4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0, 3, 1'b0);
    do_op(4'd1, 32'hFFFF_FFFF, 32'h1, 2'd1, 32'h0, 3, 1'b0);
    do_op(4'd0, 32'h7, 32'h8, 2'd0, 32'h0, 0, 1'b0);
    do_op(4'd2, 32'h22, 32'h23, 2'd2, 32'h0, 1, 1'b1);
    do_op(4'd5, 32'h3, 32'h2, 2'd1, 32'hC, 0, 1'b0);
    do_op(4'd6, 32'hC, 32'h2, 2'd1, 32'h3, 4, 1'b1);
    do_op(4'd9, 32'h1, 32'h1, 2'd3, 32'h0, TIMEOUT - 1, 1'b0);
    do_op(4'd1, 32'h1, 32'h1, 2'd2, 32'h0, TIMEOUT, 1'b0);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: cmd = 4'd0;
        1: cmd = 4'd1;
        2: cmd = 4'd2;
        3: cmd = 4'd5;
        4: cmd = 4'd6;
        default: cmd = 4'($urandom);
      endcase
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
      model(cmd, a, b, mr, md);
      if ($urandom_range(0, 9) < 7) begin dr = mr; dd = md; end
      else begin dr = 2'($urandom_range(0, 3)); dd = $urandom; end
      do_op(cmd, a, b, dr, dd, $urandom_range(0, TIMEOUT + 1), ($urandom_range(0, 3) == 0));
    end

    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge c_clk);
    chk("queue_drained", q.size(), 0);

    // Abandon an op while waiting; its late response must never surface.
    for (int k = 0; k < 100 && !op_ready; k++) @(negedge c_clk);
    @(posedge c_clk); #1;
    op_valid = 1'b1; op_cmd = 4'd1; op_data1 = 32'h5; op_data2 = 32'h1;
    @(posedge c_clk); #1;
    op_valid = 1'b0;
    repeat (3) begin @(posedge c_clk); #1; end
    reset = 1'b1;
    @(posedge c_clk);
    @(negedge c_clk);
    chk_reset_outputs("midreset");
    @(posedge c_clk); #1;
    reset = 1'b0;
    calc_resp_in = 2'd1; calc_data_in = 32'h6;
    @(posedge c_clk); #1;
    calc_resp_in = 2'd0;
    any_valid = 1'b0;
    repeat (20) begin
      @(negedge c_clk);
      if (rsp_valid) any_valid = 1'b1;
    end
    chk("late_resp_ignored", any_valid, 0);
    chk("idle_after_reset", {op_ready, req_cmd_out}, {1'b1, 4'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
